// File: rtl/lcd_frame_sched.sv
// rtl/lcd_frame_sched.sv - LCD panel power-up, init-table and frame-write byte scheduler
module lcd_frame_sched #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 240,
  parameter int RST_LOW_CYC  = 10,
  parameter int RST_WAIT_CYC = 20,
  parameter int DLY_UNIT     = 16,
  parameter int INIT_LEN     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        lcd_reset,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        init_done,
  output logic        busy
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PC_W  = (NPIX > 2) ? $clog2(NPIX) : 1;
  localparam int CNT_W = 20;
  localparam logic [15:0]     W_M1      = 16'(WIDTH - 1);
  localparam logic [15:0]     H_M1      = 16'(HEIGHT - 1);
  localparam logic [PC_W-1:0] PIX_LAST  = PC_W'(NPIX - 1);
  localparam logic [7:0]      INIT_LAST = 8'(INIT_LEN - 1);

  typedef enum logic [2:0] {
    RST_LOW, RST_WAIT, INIT, IDLE, WIN, PIX_FETCH, PIX_HI, PIX_LO
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        idx;
  logic [PC_W-1:0]   pix_cnt;
  logic [15:0]       pix_reg;
  logic [9:0]        entry;
  logic [8:0]        win_ent;
  logic [CNT_W-1:0]  dly_len;
  logic              dly_done;
  logic              init_step;

  // Entry layout {dly, dc, byte}; a delay entry waits byte*DLY_UNIT cycles.
  function automatic logic [9:0] init_rom(input logic [7:0] i);
    case (i)
      8'd0:    return 10'h001;
      8'd1:    return 10'h20A;
      8'd2:    return 10'h011;
      8'd3:    return 10'h20A;
      8'd4:    return 10'h03A;
      8'd5:    return 10'h155;
      8'd6:    return 10'h029;
      8'd7:    return 10'h202;
      default: return 10'h000;
    endcase
  endfunction

  function automatic logic [8:0] win_byte(input logic [7:0] i);
    case (i)
      8'd0:    return 9'h02A;
      8'd3:    return {1'b1, W_M1[15:8]};
      8'd4:    return {1'b1, W_M1[7:0]};
      8'd5:    return 9'h02B;
      8'd8:    return {1'b1, H_M1[15:8]};
      8'd9:    return {1'b1, H_M1[7:0]};
      8'd10:   return 9'h02C;
      default: return 9'h100;
    endcase
  endfunction

  assign entry     = init_rom(idx);
  assign win_ent   = win_byte(idx);
  assign dly_len   = CNT_W'(entry[7:0]) * CNT_W'(DLY_UNIT);
  assign dly_done  = (cnt + CNT_W'(1)) >= dly_len;
  assign init_step = entry[9] ? dly_done : tx_ready;
  assign lcd_reset = (state != RST_LOW);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RST_LOW;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_dc     = 1'b0;
    pix_ready = 1'b0;
    case (state)
      RST_LOW:  if (cnt == CNT_W'(RST_LOW_CYC - 1)) state_n = RST_WAIT;
      RST_WAIT: if (cnt == CNT_W'(RST_WAIT_CYC - 1)) state_n = INIT;
      INIT: begin
        if (!entry[9]) begin
          tx_valid = 1'b1;
          tx_dc    = entry[8];
          tx_data  = entry[7:0];
        end
        if (init_step && idx == INIT_LAST) state_n = IDLE;
      end
      IDLE: if (frame_start) state_n = WIN;
      WIN: begin
        tx_valid         = 1'b1;
        {tx_dc, tx_data} = win_ent;
        if (tx_ready && idx == 8'd10) state_n = PIX_FETCH;
      end
      PIX_FETCH: begin
        pix_ready = 1'b1;
        if (pix_valid) state_n = PIX_HI;
      end
      PIX_HI: begin
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = pix_reg[15:8];
        if (tx_ready) state_n = PIX_LO;
      end
      PIX_LO: begin
        tx_valid = 1'b1;
        tx_dc    = 1'b1;
        tx_data  = pix_reg[7:0];
        if (tx_ready) state_n = (pix_cnt == PIX_LAST) ? IDLE : PIX_FETCH;
      end
      default: state_n = RST_LOW;
    endcase
  end

  // idx is shared between the init table and the window byte sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      pix_cnt   <= '0;
      pix_reg   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        RST_LOW, RST_WAIT: cnt <= (state_n != state) ? '0 : cnt + CNT_W'(1);
        INIT: begin
          cnt <= (entry[9] && !dly_done) ? cnt + CNT_W'(1) : '0;
          if (init_step) idx <= (idx == INIT_LAST) ? 8'd0 : idx + 8'd1;
          if (init_step && idx == INIT_LAST) init_done <= 1'b1;
        end
        IDLE:      pix_cnt <= '0;
        WIN:       if (tx_ready) idx <= (idx == 8'd10) ? 8'd0 : idx + 8'd1;
        PIX_FETCH: if (pix_valid) pix_reg <= pix_data;
        PIX_LO:    if (tx_ready) pix_cnt <= pix_cnt + PC_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sched.sv
// tb/tb_lcd_frame_sched.sv - directed bench for lcd_frame_sched (240x4 panel to keep frames short)
module tb_lcd_frame_sched;

  localparam int TW   = 240;
  localparam int TH   = 4;
  localparam int NPIX = TW * TH;

  logic        clk;
  logic        rst_n;
  logic        lcd_reset;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        frame_start;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_ready;
  logic        init_done;
  logic        busy;

  lcd_frame_sched #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_reset(lcd_reset), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_dc(tx_dc), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .init_done(init_done), .busy(busy)
  );

  typedef struct {
    string      name;
    logic [8:0] exp;
  } vec_t;

  vec_t init_tab[5];
  vec_t win_tab[11];
  vec_t pix_tab[4];

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         e29 = 0;
  int         pix_n = 0;
  int         stab_checks = 0;
  int         stab_errs = 0;
  logic       rand_rdy = 1'b0;
  logic       rdy_fix = 1'b1;
  logic       hold_pend = 1'b0;
  logic [8:0] hold_val = '0;
  logic [8:0] cap[$];

  function automatic logic [15:0] pix_val(input int n);
    if (n == 0) return 16'h1234;
    if (n == 1) return 16'hABCD;
    return 16'(n * 40503 + 7);
  endfunction

  function automatic logic [8:0] cap_at(input int i);
    if (i < cap.size()) return cap[i];
    return 9'h1FF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 tx_ready = rand_rdy ? ($urandom_range(0, 99) < 30) : rdy_fix;
    end
  end

  initial begin
    pix_data = pix_val(0);
    forever begin
      @(posedge clk);
      if (pix_valid && pix_ready) pix_n++;
      #1 pix_data = pix_val(pix_n);
    end
  end

  // Byte capture plus hold-stability tracking while the writer stalls.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && tx_valid && tx_ready) begin
        cap.push_back({tx_dc, tx_data});
        if ({tx_dc, tx_data} == 9'h029) e29 = cyc;
      end
      if (rst_n && hold_pend) begin
        stab_checks++;
        if (!tx_valid || {tx_dc, tx_data} != hold_val) stab_errs++;
      end
      hold_pend = rst_n && tx_valid && !tx_ready;
      hold_val  = {tx_dc, tx_data};
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_lcd_reset"}, lcd_reset, 0);
    chk({tag, "_tx_valid"},  tx_valid,  0);
    chk({tag, "_tx_data"},   tx_data,   0);
    chk({tag, "_tx_dc"},     tx_dc,     0);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_busy"},      busy,      1);
  endtask

  task automatic power_up(input string tag);
    int n;
    cap.delete();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!lcd_reset && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_rst_low_cyc"}, n, 10);
    n = 0;
    while (!tx_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_rst_wait_cyc"}, n, 20);
    chk({tag, "_first_byte"}, {tx_dc, tx_data}, 9'h001);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_init_done"}, init_done, 1);
    chk({tag, "_init_tail"}, cyc - e29, 32);
    repeat (20) @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_init_len"}, cap.size(), 5);
    for (int i = 0; i < 5; i++) chk({tag, "_", init_tab[i].name}, cap_at(i), init_tab[i].exp);
  endtask

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin @(negedge clk); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic check_frame(input string tag, input int base);
    int bad;
    logic [15:0] p;
    chk({tag, "_len"}, cap.size(), 11 + 2 * NPIX);
    for (int i = 0; i < 11; i++) chk({tag, "_", win_tab[i].name}, cap_at(i), win_tab[i].exp);
    bad = 0;
    for (int k = 0; k < NPIX; k++) begin
      p = pix_val(base + k);
      if (cap_at(11 + 2 * k) != {1'b1, p[15:8]}) bad++;
      if (cap_at(12 + 2 * k) != {1'b1, p[7:0]})  bad++;
    end
    chk({tag, "_pix_bytes_bad"}, bad, 0);
  endtask

  initial begin
    int base;
    int n;
    init_tab = '{'{"i_swreset", 9'h001}, '{"i_slpout", 9'h011}, '{"i_colmod", 9'h03A},
                 '{"i_colmod_arg", 9'h155}, '{"i_dispon", 9'h029}};
    win_tab  = '{'{"w_caset", 9'h02A}, '{"w_xs_hi", 9'h100}, '{"w_xs_lo", 9'h100},
                 '{"w_xe_hi", 9'h100}, '{"w_xe_lo", 9'h1EF}, '{"w_raset", 9'h02B},
                 '{"w_ys_hi", 9'h100}, '{"w_ys_lo", 9'h100}, '{"w_ye_hi", 9'h100},
                 '{"w_ye_lo", 9'h103}, '{"w_ramwr", 9'h02C}};
    pix_tab  = '{'{"p0_hi", 9'h112}, '{"p0_lo", 9'h134}, '{"p1_hi", 9'h1AB}, '{"p1_lo", 9'h1CD}};

    rst_n = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    power_up("pu");

    // Frame 1: pixel source starts empty, then a frame_start arrives mid-frame.
    cap.delete();
    base = pix_n;
    start_frame();
    chk("f1_start_busy", busy, 1);
    n = 0;
    while (!pix_ready && n < 100) begin @(negedge clk); n++; end
    chk("f1_fetch_reached", pix_ready, 1);
    repeat (5) @(negedge clk);
    chk("f1_stall_tx_valid", tx_valid, 0);
    chk("f1_stall_pix_ready", pix_ready, 1);
    chk("f1_stall_busy", busy, 1);
    pix_valid = 1'b1;
    repeat (100) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_idle("f1_done", 20000);
    repeat (30) @(negedge clk);
    chk("f1_stays_idle", busy, 0);
    check_frame("f1", base);
    for (int i = 0; i < 4; i++) chk({"f1_", pix_tab[i].name}, cap_at(11 + i), pix_tab[i].exp);

    // Frame 2: tx_ready high ~30% of cycles.
    cap.delete();
    base = pix_n;
    rand_rdy = 1'b1;
    start_frame();
    wait_idle("f2_done", 40000);
    rand_rdy = 1'b0;
    repeat (30) @(negedge clk);
    check_frame("f2", base);
    chk("f2_tx_stable_errs", stab_errs, 0);
    chk("f2_stalls_seen", stab_checks > 0, 1);

    // Frame 3: asynchronous reset at pixel 500, then full power-up again.
    cap.delete();
    base = pix_n;
    start_frame();
    n = 0;
    while ((pix_n - base) < 500 && n < 5000) begin @(negedge clk); n++; end
    chk("f3_px500_reached", (pix_n - base) >= 500, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    repeat (2) @(negedge clk);
    power_up("pu2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_frame_sched.md
LCD_FRAME_SCHED -- requirements
Module: lcd_frame_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 240: panel columns.
REQ-002 SHALL have parameter HEIGHT, default 240: panel rows.
REQ-003 SHALL have parameter RST_LOW_CYC, default 10: clk cycles lcd_reset is held low after reset release.
REQ-004 SHALL have parameter RST_WAIT_CYC, default 20: clk cycles waited after lcd_reset rises, before the first init byte.
REQ-005 SHALL have parameter DLY_UNIT, default 16: clk cycles per unit of an init-table delay entry.
REQ-006 SHALL have parameter INIT_LEN, default 8: number of init-table entries.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port lcd_reset, output, 1 bit: panel hardware reset, active low.
REQ-010 SHALL have port tx_valid, output, 1 bit: byte offered to the SPI byte writer.
REQ-011 SHALL have port tx_ready, input, 1 bit: SPI byte writer accepts; a transfer occurs when tx_valid & tx_ready.
REQ-012 SHALL have port tx_data, output, 8 bits: byte to send.
REQ-013 SHALL have port tx_dc, output, 1 bit: 0 = command, 1 = data; drives lcd_dc through the writer.
REQ-014 SHALL have port frame_start, input, 1 bit: single-cycle request to write one full frame.
REQ-015 SHALL have port pix_valid, input, 1 bit: pixel source has data.
REQ-016 SHALL have port pix_data, input, 16 bits: RGB565 pixel.
REQ-017 SHALL have port pix_ready, output, 1 bit: pixel accepted when pix_valid & pix_ready.
REQ-018 SHALL have port init_done, output, 1 bit: init sequence complete, level.
REQ-019 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-020 SHALL implement the states RST_LOW, RST_WAIT, INIT, IDLE, WIN, PIX_FETCH, PIX_HI and PIX_LO.
REQ-021 RST_LOW SHALL hold lcd_reset=0 for RST_LOW_CYC cycles, then go to RST_WAIT with lcd_reset=1.
REQ-022 RST_WAIT SHALL count RST_WAIT_CYC cycles, then go to INIT.
REQ-023 The init table SHALL be an internal constant ROM of 10-bit entries {dly, dc, byte}; dly=1 means wait byte*DLY_UNIT cycles and send nothing; dly=0 means send byte with tx_dc=dc.
REQ-024 The default init table SHALL be: cmd 0x01; delay 10; cmd 0x11; delay 10; cmd 0x3A; data 0x55; cmd 0x29; delay 2.
REQ-025 After the last init entry completes, init_done SHALL rise, remain high until reset, and the FSM SHALL enter IDLE.
REQ-026 In IDLE, a frame_start pulse SHALL move the FSM to WIN on the next cycle; frame_start in any other state SHALL be ignored and not queued.
REQ-027 WIN SHALL send exactly 11 bytes in order: cmd 0x2A; data 0x00, 0x00, (WIDTH-1)[15:8], (WIDTH-1)[7:0]; cmd 0x2B; data 0x00, 0x00, (HEIGHT-1)[15:8], (HEIGHT-1)[7:0]; cmd 0x2C.
REQ-028 PIX_FETCH SHALL assert pix_ready=1 and latch pix_data on handshake; pix_ready SHALL be 0 in all other states.
REQ-029 PIX_HI SHALL send pix[15:8], then PIX_LO SHALL send pix[7:0], both with tx_dc=1.
REQ-030 The pixel counter SHALL be clog2(WIDTH*HEIGHT) bits; after the byte of pixel WIDTH*HEIGHT-1 is accepted in PIX_LO, the FSM SHALL return to IDLE, otherwise it SHALL return to PIX_FETCH.
REQ-031 Handshake: once tx_valid=1, tx_data and tx_dc SHALL stay stable until accepted; tx_valid SHALL be 0 in RST_*, IDLE, PIX_FETCH and during delay entries.
REQ-032 A byte is accepted in the cycle where tx_valid & tx_ready; the next byte SHALL be offered no earlier than the following cycle.
REQ-033 If tx_ready is held low, the FSM SHALL stall indefinitely without dropping or repeating bytes.
REQ-034 If pix_valid is held low in PIX_FETCH, the FSM SHALL stall with tx_valid=0.

Reset
REQ-035 When rst_n=0 (asynchronous), the block SHALL force: state RST_LOW, lcd_reset=0, tx_valid=0, tx_data=0, tx_dc=0, pix_ready=0, init_done=0, busy=1, all counters 0.
REQ-036 A reset asserted mid-frame or mid-init SHALL abort the operation; after release the full reset and init sequence SHALL rerun.

Verification
REQ-037 Power-up with tx_ready=1: lcd_reset low for 10 cycles; the first tx byte is 0x01 (dc=0) exactly 20 cycles after lcd_reset rises; init_done=1 after 0x29 plus a 32-cycle delay.
REQ-038 frame_start in IDLE with tx_ready=1: byte stream 2A 00 00 00 EF 2B 00 00 00 EF 2C, with dc pattern 0,1,1,1,1,0,1,1,1,1,0.
REQ-039 Pixels 0x1234 then 0xABCD: data bytes 12 34 AB CD, dc=1; after 57600 pixels, busy=0.
REQ-040 Toggle tx_ready randomly, 30% high: byte stream identical to REQ-038/039 with no loss, and tx_data stable while tx_valid & !tx_ready.
REQ-041 frame_start during INIT and mid-frame: ignored, with exactly one frame emitted.
REQ-042 rst_n pulsed low at pixel 1000: outputs return to reset values immediately, and the init sequence repeats from RST_LOW.
